lcd_status_reader: RTL
======================

// Module: lcd_status_reader
// PURPOSE
//  Read-side companion to the HD44780 write path in the vending-machine LCD controller.
//  Runs HD44780 read cycles (RW=1) on the shared 8-bit bus:
//   - status read (RS=0): busy flag BF plus the 7-bit address counter AC.
//   - DDRAM/CGRAM data read (RS=1).
//  Status reads can optionally poll until BF=0, so the writer can wait on BF instead of fixed delays.
//  Owns the LCD control pins only while bus_own=1; the top-level mux releases LCD_DATA (tri-state) during that time.
// PARAMETERS
//  T_AS     3     setup cycles, RS/RW valid before E rises (>=40ns at 50MHz)
//  T_PW     13    E high cycles (>=230ns)
//  T_SAMPLE 10    E-high cycles before lcd_data_in is captured (>=160ns tDDR); must satisfy 1 <= T_SAMPLE < T_PW
//  T_AH     2     hold cycles after E falls, RW still 1
//  T_GAP    12    recovery cycles, RW=0, bus released; total cycle >=500ns
//  POLL_MAX 4096  maximum status reads per poll before timeout
// PORTS
//  CLOCK_50    in   1  50MHz clock
//  RST         in   1  synchronous reset, active-high
//  rd_req      in   1  start a read; sampled only while ready=1
//  rd_rs       in   1  0=status read, 1=data RAM read; latched on accept
//  poll_bf     in   1  with rd_rs=0: repeat reads until BF=0; ignored when rd_rs=1
//  ready       out  1  block idle, can accept rd_req
//  rd_valid    out  1  one-cycle pulse; result outputs valid from this cycle until next accept
//  rd_data     out  8  last captured bus byte
//  busy_flag   out  1  rd_data[7] of last status read
//  addr_cnt    out  7  rd_data[6:0] of last status read
//  timeout     out  1  one-cycle pulse coincident with rd_valid when poll gives up
//  bus_own     out  1  reader drives lcd_rs/rw/en; the bus must be tri-stated
//  lcd_rs      out  1  register select to the pin mux
//  lcd_rw      out  1  read/write select to the pin mux
//  lcd_en      out  1  enable to the pin mux
//  lcd_data_in in   8  LCD_DATA as seen at the pin
// BEHAVIOUR
//  Reset values:
//   - lcd_en=0, lcd_rw=0, lcd_rs=0, bus_own=0.
//   - rd_valid=0, timeout=0, rd_data=0, busy_flag=0, addr_cnt=0.
//   - state=IDLE, so ready=1. All outputs are registered; ready = (state==IDLE).
//  FSM: IDLE -> SETUP -> EN_HI -> HOLD -> GAP -> {SETUP | IDLE}.
//  Cycle timing, with the accept at edge 0 (rd_req=1 and ready=1):
//   - Edge 0: lcd_rw<=1, lcd_rs<=rd_rs, bus_own<=1, poll count cleared.
//   - Edge T_AS: lcd_en<=1.
//   - Edge T_AS+T_SAMPLE: rd_data<=lcd_data_in; if rs=0, busy_flag/addr_cnt are also updated.
//   - Edge T_AS+T_PW: lcd_en<=0.
//   - Edge T_AS+T_PW+T_AH: lcd_rw<=0, bus_own<=0. lcd_rs holds its value.
//   - Edge L=T_AS+T_PW+T_AH+T_GAP (30 at defaults): end of GAP.
//  Decision at end of GAP:
//   - Poll active and BF=1 and count<POLL_MAX-1: count++, re-enter SETUP; lcd_rw<=1, bus_own<=1 at that edge.
//   - Otherwise: state<=IDLE and rd_valid<=1; timeout<=1 only when the poll ran out with BF=1.
//  Latency: a single read gives rd_valid at edge 30 after accept; each poll iteration adds 30 cycles.
//  rd_req while not ready is ignored, not queued. A held rd_req re-triggers on the cycle ready rises.
//  Reset mid-operation: at the next edge, lcd_en/lcd_rw/bus_own drop to 0 and no rd_valid is issued.
//  Timeout: after POLL_MAX reads all with BF=1, rd_data holds the last read (BF=1).
//  Exactly one rd_valid per accepted request.
// STRUCTURE
//  lcd_pkg holds:
//   - default timing constants and the 50MHz clock figure;
//   - the state encoding;
//   - HD44780 field constants BF_BIT=7 and AC_W=7.
//  One sub-module, lcd_phase_timer: a loadable down-counter with a zero flag, reused for every phase.
//  The poll counter is local and $clog2(POLL_MAX) bits wide.
// TESTING
//  1. Reset, then rd_req with rd_rs=0 while bus shows 8'h25:
//     lcd_en high edges 3..15; rd_valid at edge 30; busy_flag=0, addr_cnt=7'h25, timeout=0.
//  2. rd_rs=1 while bus shows 8'hA7:
//     rd_valid at edge 30, rd_data=8'hA7; busy_flag/addr_cnt unchanged; lcd_rs=1 throughout.
//  3. Poll with bus 8'h80 for 3 reads then 8'h05:
//     4 E pulses; rd_valid at edge 120 with addr_cnt=7'h05, timeout=0.
//  4. POLL_MAX=4, bus stuck at 8'hFF:
//     4 E pulses; rd_valid and timeout together at edge 120; rd_data=8'hFF.
//  5. RST pulse at edge 8 (E high):
//     lcd_en=lcd_rw=bus_own=0 next cycle; no rd_valid; ready=1.
//  6. Extra rd_req pulses mid-cycle are ignored; data change at edge 12 vs 14 proves sampling exactly at edge 13.
//     Checker: E width, setup and hold counts, and cycle >=25 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 status/data read path.
// Timing defaults assume a 50 MHz clock (20 ns per cycle).
package lcd_pkg;

   localparam int CLK_HZ = 50_000_000;

   localparam int DEF_T_AS     = 3;
   localparam int DEF_T_PW     = 13;
   localparam int DEF_T_SAMPLE = 10;
   localparam int DEF_T_AH     = 2;
   localparam int DEF_T_GAP    = 12;
   localparam int DEF_POLL_MAX = 4096;

   localparam int TIMER_W = 8;

   localparam int BF_BIT = 7;
   localparam int AC_W   = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_EN_HI,
      ST_HOLD,
      ST_GAP
   } rd_state_t;

   function automatic int read_cycle_len(input int t_as, input int t_pw,
                                         input int t_ah, input int t_gap);
      return t_as + t_pw + t_ah + t_gap;
   endfunction

   localparam int DEF_CYCLE = read_cycle_len(DEF_T_AS, DEF_T_PW, DEF_T_AH, DEF_T_GAP);

endpackage

// File: rtl/lcd_status_reader_if.sv
// Request/result handshake between the LCD writer (master) and the status reader (slave).
interface lcd_status_reader_if;
   import lcd_pkg::*;

   logic            rd_req;
   logic            rd_rs;
   logic            poll_bf;
   logic            ready;
   logic            rd_valid;
   logic [7:0]      rd_data;
   logic            busy_flag;
   logic [AC_W-1:0] addr_cnt;
   logic            timeout;

   modport master (
      output rd_req, rd_rs, poll_bf,
      input  ready, rd_valid, rd_data, busy_flag, addr_cnt, timeout
   );

   modport slave (
      input  rd_req, rd_rs, poll_bf,
      output ready, rd_valid, rd_data, busy_flag, addr_cnt, timeout
   );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that parks at zero; the reader reloads it on every phase change.
module lcd_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);

   // A load of N-1 makes zero visible on the Nth edge after the load.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-cycle engine: status reads (optionally polled until BF=0) and RAM data reads.
// Drives RS/RW/E to the pin mux only while bus_own is high.
module lcd_status_reader
   import lcd_pkg::*;
#(
   parameter int T_AS     = DEF_T_AS,
   parameter int T_PW     = DEF_T_PW,
   parameter int T_SAMPLE = DEF_T_SAMPLE,
   parameter int T_AH     = DEF_T_AH,
   parameter int T_GAP    = DEF_T_GAP,
   parameter int POLL_MAX = DEF_POLL_MAX
) (
   input  logic                CLOCK_50,
   input  logic                RST,
   lcd_status_reader_if.slave  host,
   output logic                bus_own,
   output logic                lcd_rs,
   output logic                lcd_rw,
   output logic                lcd_en,
   input  logic [7:0]          lcd_data_in
);

   localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

   localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(T_AS - 1);
   localparam logic [TIMER_W-1:0] EN_LD     = TIMER_W'(T_PW - 1);
   localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(T_AH - 1);
   localparam logic [TIMER_W-1:0] GAP_LD    = TIMER_W'(T_GAP - 1);
   localparam logic [TIMER_W-1:0] SAMPLE_AT = TIMER_W'(T_PW - T_SAMPLE);
   localparam logic [PCW-1:0]     POLL_LAST = PCW'(POLL_MAX - 1);

   rd_state_t           state;
   logic                poll_q;
   logic [PCW-1:0]      poll_cnt;
   logic                rd_valid_q;
   logic                timeout_q;
   logic [7:0]          rd_data_q;
   logic                busy_flag_q;
   logic [AC_W-1:0]     addr_cnt_q;

   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_val;
   logic [TIMER_W-1:0]  tmr_count;
   logic                tmr_zero;
   logic                poll_again;

   lcd_phase_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk      (CLOCK_50),
      .rst      (RST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   // rd_data still holds this iteration's byte at the end of GAP, so its BF decides the retry.
   assign poll_again = poll_q && rd_data_q[BF_BIT] && (poll_cnt < POLL_LAST);

   // Reload the phase timer on exactly the edges where the FSM changes phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: begin
            if (host.rd_req) begin
               tmr_load = 1'b1;
               tmr_val  = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = EN_LD;
            end
         end
         ST_EN_HI: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end
         ST_GAP: begin
            if (tmr_zero && poll_again) begin
               tmr_load = 1'b1;
               tmr_val  = SETUP_LD;
            end
         end
         default: begin
            tmr_load = 1'b0;
            tmr_val  = '0;
         end
      endcase
   end

   // Read-cycle sequencer; every pin and result output is a register of this block.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         state       <= ST_IDLE;
         lcd_en      <= 1'b0;
         lcd_rw      <= 1'b0;
         lcd_rs      <= 1'b0;
         bus_own     <= 1'b0;
         poll_q      <= 1'b0;
         poll_cnt    <= '0;
         rd_valid_q  <= 1'b0;
         timeout_q   <= 1'b0;
         rd_data_q   <= '0;
         busy_flag_q <= 1'b0;
         addr_cnt_q  <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         timeout_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (host.rd_req) begin
                  state    <= ST_SETUP;
                  lcd_rw   <= 1'b1;
                  lcd_rs   <= host.rd_rs;
                  bus_own  <= 1'b1;
                  poll_q   <= host.poll_bf & ~host.rd_rs;
                  poll_cnt <= '0;
               end
            end
            ST_SETUP: begin
               if (tmr_zero) begin
                  state  <= ST_EN_HI;
                  lcd_en <= 1'b1;
               end
            end
            ST_EN_HI: begin
               if (tmr_count == SAMPLE_AT) begin
                  rd_data_q <= lcd_data_in;
                  if (!lcd_rs) begin
                     busy_flag_q <= lcd_data_in[BF_BIT];
                     addr_cnt_q  <= lcd_data_in[AC_W-1:0];
                  end
               end
               if (tmr_zero) begin
                  state  <= ST_HOLD;
                  lcd_en <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (tmr_zero) begin
                  state   <= ST_GAP;
                  lcd_rw  <= 1'b0;
                  bus_own <= 1'b0;
               end
            end
            ST_GAP: begin
               if (tmr_zero) begin
                  if (poll_again) begin
                     state    <= ST_SETUP;
                     poll_cnt <= poll_cnt + PCW'(1);
                     lcd_rw   <= 1'b1;
                     bus_own  <= 1'b1;
                  end else begin
                     state      <= ST_IDLE;
                     rd_valid_q <= 1'b1;
                     timeout_q  <= poll_q & rd_data_q[BF_BIT];
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign host.ready     = (state == ST_IDLE);
   assign host.rd_valid  = rd_valid_q;
   assign host.timeout   = timeout_q;
   assign host.rd_data   = rd_data_q;
   assign host.busy_flag = busy_flag_q;
   assign host.addr_cnt  = addr_cnt_q;

endmodule
